// File: rtl/video_pkg.sv
// Shared sizes and reader state encoding for the scandoubler line-buffer control.
package video_pkg;

    localparam int unsigned LINE_PIXELS = 256;
    localparam int unsigned VIS_LINES   = 240;
    localparam int unsigned BANK_AW     = 8;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        HOLD
    } reader_state_t;

endpackage

// File: rtl/scanline_scheduler.sv
// Two-bank scandoubler sequencer: PPU lines are written to one bank and each full bank is
// replayed on two VGA lines. Optional SCANLINE_DIM_EN drives dim on the second replay.
module scanline_scheduler
    import video_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pix_ce,
    input  logic [5:0] color,
    input  logic [8:0] count_h,
    input  logic [8:0] count_v,
    input  logic       line_req,
    input  logic       rd_ce,
    output logic       wr_en,
    output logic [8:0] wr_addr,
    output logic [5:0] wr_data,
    output logic [8:0] rd_addr,
    output logic       line_valid,
    output logic       dim,
    output logic       overrun,
    output logic       underrun,
    output logic       frame_start
);

    reader_state_t        state_q, state_d;
    logic [1:0]           full_q, full_d;
    logic                 wbank_q, wbank_d;
    logic                 nbank_q, nbank_d;
    logic                 rbank_q, rbank_d;
    logic                 pass_q, pass_d;
    logic [BANK_AW-1:0]   rd_x_q, rd_x_d;
    logic                 seen_q, seen_d;

    logic                 wr_en_q, wr_en_d;
    logic [8:0]           wr_addr_q, wr_addr_d;
    logic [5:0]           wr_data_q, wr_data_d;
    logic [8:0]           rd_addr_q, rd_addr_d;
    logic                 line_valid_q, line_valid_d;
    logic                 dim_q, dim_d;
    logic                 overrun_q, overrun_d;
    logic                 underrun_q, underrun_d;
    logic                 frame_start_q, frame_start_d;

    logic                 fs;
    logic                 in_vis;
    logic                 wr_fire;
    logic                 wr_bank;
    logic [1:0]           full_avail;

    always_comb begin
        state_d       = state_q;
        full_d        = full_q;
        wbank_d       = wbank_q;
        nbank_d       = nbank_q;
        rbank_d       = rbank_q;
        pass_d        = pass_q;
        rd_x_d        = rd_x_q;
        seen_d        = seen_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        overrun_d     = overrun_q;
        underrun_d    = underrun_q;
        frame_start_d = 1'b0;
        full_avail    = full_q;

        fs      = pix_ce && (count_v == 9'd0) && (count_h == 9'd0);
        in_vis  = (count_h < 9'(LINE_PIXELS)) && (count_v < 9'(VIS_LINES));
        // Frame start forces pixel 0 into bank 0 regardless of stale full flags.
        wr_fire = pix_ce && in_vis && (fs || !full_q[wbank_q]);
        wr_bank = fs ? 1'b0 : wbank_q;

        if (wr_fire) begin
            wr_en_d   = 1'b1;
            wr_addr_d = {wr_bank, count_h[BANK_AW-1:0]};
            wr_data_d = color;
        end

        if (fs) begin
            full_d        = 2'b00;
            wbank_d       = 1'b0;
            nbank_d       = 1'b0;
            seen_d        = 1'b0;
            state_d       = IDLE;
            frame_start_d = 1'b1;
        end else begin
            // Commit checks the other bank's pre-clear flag, so a same-cycle free is not seen.
            if (wr_fire && (count_h == 9'(LINE_PIXELS - 1))) begin
                if (full_q[~wbank_q]) begin
                    overrun_d = 1'b1;
                end else begin
                    full_d[wbank_q] = 1'b1;
                    wbank_d         = ~wbank_q;
                end
            end

            if (line_req) begin
                if ((state_q != IDLE) && !pass_q) begin
                    pass_d  = 1'b1;
                    rd_x_d  = '0;
                    state_d = READ;
                end else begin
                    if (state_q != IDLE) begin
                        full_avail[rbank_q] = 1'b0;
                        full_d[rbank_q]     = 1'b0;
                    end
                    if (full_avail[nbank_q]) begin
                        rbank_d = nbank_q;
                        nbank_d = ~nbank_q;
                        pass_d  = 1'b0;
                        rd_x_d  = '0;
                        seen_d  = 1'b1;
                        state_d = READ;
                    end else begin
                        state_d = IDLE;
                        if (seen_q) begin
                            underrun_d = 1'b1;
                        end
                    end
                end
            end else if (rd_ce && (state_q == READ)) begin
                rd_x_d = rd_x_q + 1'b1;
                if (rd_x_q == '1) begin
                    state_d = HOLD;
                end
            end
        end

        line_valid_d = (state_d != IDLE);
        rd_addr_d    = {rbank_d, rd_x_d};
`ifdef SCANLINE_DIM_EN
        dim_d        = pass_d && line_valid_d;
`else
        dim_d        = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            full_q        <= 2'b00;
            wbank_q       <= 1'b0;
            nbank_q       <= 1'b0;
            rbank_q       <= 1'b0;
            pass_q        <= 1'b0;
            rd_x_q        <= '0;
            seen_q        <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            rd_addr_q     <= '0;
            line_valid_q  <= 1'b0;
            dim_q         <= 1'b0;
            overrun_q     <= 1'b0;
            underrun_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            full_q        <= full_d;
            wbank_q       <= wbank_d;
            nbank_q       <= nbank_d;
            rbank_q       <= rbank_d;
            pass_q        <= pass_d;
            rd_x_q        <= rd_x_d;
            seen_q        <= seen_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            rd_addr_q     <= rd_addr_d;
            line_valid_q  <= line_valid_d;
            dim_q         <= dim_d;
            overrun_q     <= overrun_d;
            underrun_q    <= underrun_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign rd_addr     = rd_addr_q;
    assign line_valid  = line_valid_q;
    assign dim         = dim_q;
    assign overrun     = overrun_q;
    assign underrun    = underrun_q;
    assign frame_start = frame_start_q;

endmodule
